contador_pasos_n: RTL and testbench

- Parametrised successor of the fixed 3-bit sensor/counter chain.
- Takes two raw sensor inputs (a, b) from a passage such as a doorway or lane. Internally it synchronises and debounces both, then decodes traversal direction with a state machine.
- Maintains a WIDTH-bit occupancy count bounded by CAPACITY, with full/empty flags, error reporting and a synchronous clear.
- Drives LEDs or a display directly through the count output.

---
 rtl/contador_pasos_n_if.sv | 16 +
 rtl/contador_pasos_n.sv | 96 +++++++++
 tb/tb_contador_pasos_n.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/contador_pasos_n_if.sv
// contador_pasos_n_if: sensor, clear and occupancy signals of the passage counter
// slave  (counter): a, b, clear in; count, entry_pulse, exit_pulse, full, empty, err out
// master (driver) : the same signals in the opposite directions
interface contador_pasos_n_if #(parameter int WIDTH = 8);
  logic a;
  logic b;
  logic clear;
  logic [WIDTH-1:0] count;
  logic entry_pulse;
  logic exit_pulse;
  logic full;
  logic empty;
  logic err;
  modport slave (input a, b, clear, output count, entry_pulse, exit_pulse, full, empty, err);
  modport master (output a, b, clear, input count, entry_pulse, exit_pulse, full, empty, err);
endinterface

// File: rtl/contador_pasos_n.sv
// contador_pasos_n: debounced two-sensor passage decoder with saturating occupancy count
// clk   : system clock
// reset : asynchronous active-low reset
// bus   : slave side of contador_pasos_n_if
//         (raw sensors a/b, clear in; count, pulses, full/empty, sticky err out)
module contador_pasos_n #(
  parameter int WIDTH = 8,
  parameter int CAPACITY = 200,
  parameter int DEB_CYCLES = 50000
) (
  input logic clk,
  input logic reset,
  contador_pasos_n_if.slave bus
);
  localparam int CW = $clog2(DEB_CYCLES);
  typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3, BAD} state_t;
  logic [1:0] w_raw;
  logic [1:0] r_s1, r_s2, r_deb;
  logic [1:0][CW-1:0] r_dcnt;
  logic [1:0] w_ab;
  state_t r_state;
  logic r_ent, r_ext;
  logic [WIDTH-1:0] r_count, w_next;
  logic w_inc, w_dec, w_rej;
  logic r_entry, r_exit, r_full, r_empty, r_err;
  assign w_raw = {bus.b, bus.a};
  // Two-flop synchroniser, then a per-channel stability counter: the debounced
  // level only follows after DEB_CYCLES consecutive differing cycles.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_deb <= '0;
      r_dcnt <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < 2; i++)
        if (r_s2[i] == r_deb[i]) r_dcnt[i] <= '0;
        else if (r_dcnt[i] == CW'(DEB_CYCLES - 1)) begin
          r_deb[i] <= r_s2[i];
          r_dcnt[i] <= '0;
        end else r_dcnt[i] <= r_dcnt[i] + 1'b1;
    end
  // {da, db}: 2'b10 means only the outer sensor is covered
  assign w_ab = {r_deb[0], r_deb[1]};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_ent <= 1'b0;
      r_ext <= 1'b0;
    end else begin
      r_ent <= r_state == E3 && w_ab == 2'b00;
      r_ext <= r_state == X3 && w_ab == 2'b00;
      case (r_state)
        IDLE: r_state <= w_ab == 2'b10 ? E1 : w_ab == 2'b01 ? X1 : w_ab == 2'b11 ? BAD : IDLE;
        E1:   r_state <= w_ab == 2'b11 ? E2 : w_ab == 2'b00 ? IDLE : w_ab == 2'b01 ? BAD : E1;
        E2:   r_state <= w_ab == 2'b01 ? E3 : w_ab == 2'b10 ? E1 : w_ab == 2'b00 ? BAD : E2;
        E3:   r_state <= w_ab == 2'b00 ? IDLE : w_ab == 2'b11 ? E2 : w_ab == 2'b10 ? BAD : E3;
        X1:   r_state <= w_ab == 2'b11 ? X2 : w_ab == 2'b00 ? IDLE : w_ab == 2'b10 ? BAD : X1;
        X2:   r_state <= w_ab == 2'b10 ? X3 : w_ab == 2'b01 ? X1 : w_ab == 2'b00 ? BAD : X2;
        X3:   r_state <= w_ab == 2'b00 ? IDLE : w_ab == 2'b11 ? X2 : w_ab == 2'b01 ? BAD : X3;
        BAD:  r_state <= w_ab == 2'b00 ? IDLE : BAD;
        default: r_state <= IDLE;
      endcase
    end
  always_comb begin
    w_inc = r_ent && r_count != WIDTH'(CAPACITY);
    w_dec = r_ext && r_count != '0;
    w_rej = (r_ent && !w_inc) || (r_ext && !w_dec) || r_state == BAD;
    w_next = w_inc ? r_count + 1'b1 : w_dec ? r_count - 1'b1 : r_count;
  end
  // clear outranks a same-cycle event, which is simply dropped
  always_ff @(posedge clk or negedge reset)
    if (!reset || bus.clear) begin
      r_count <= '0;
      r_full <= 1'b0;
      r_empty <= 1'b1;
      r_err <= 1'b0;
      r_entry <= 1'b0;
      r_exit <= 1'b0;
    end else begin
      r_count <= w_next;
      r_full <= w_next == WIDTH'(CAPACITY);
      r_empty <= w_next == '0;
      r_err <= r_err || w_rej;
      r_entry <= w_inc;
      r_exit <= w_dec;
    end
  assign bus.count = r_count;
  assign bus.full = r_full;
  assign bus.empty = r_empty;
  assign bus.err = r_err;
  assign bus.entry_pulse = r_entry;
  assign bus.exit_pulse = r_exit;
endmodule

// File: tb/tb_contador_pasos_n.sv
// tb_contador_pasos_n: scoreboard bench for contador_pasos_n (WIDTH=4, CAPACITY=5, DEB_CYCLES=4)
module tb_contador_pasos_n;
  localparam int WIDTH = 4;
  localparam int CAP = 5;
  localparam int DEB = 4;
  typedef struct {
    logic is_entry;
    int cnt;
    logic full;
    logic empty;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  contador_pasos_n_if #(.WIDTH(WIDTH)) bus ();
  contador_pasos_n #(.WIDTH(WIDTH), .CAPACITY(CAP), .DEB_CYCLES(DEB)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int m_count = 0;
  logic m_err = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (reset && (bus.entry_pulse || bus.exit_pulse)) begin
      if (sb.size() == 0) chk("unexpected_pulse", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind_entry", 32'(bus.entry_pulse), 32'(e.is_entry));
        chk("pulse_kind_exit", 32'(bus.exit_pulse), 32'(!e.is_entry));
        chk("pulse_count", 32'(bus.count), 32'(e.cnt));
        chk("pulse_full", 32'(bus.full), 32'(e.full));
        chk("pulse_empty", 32'(bus.empty), 32'(e.empty));
      end
    end
  task automatic hold(input logic va, input logic vb, input int n);
    bus.a = va;
    bus.b = vb;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic entry();
    if (m_count < CAP) begin
      m_count++;
      sb.push_back('{1'b1, m_count, m_count == CAP, 1'b0});
    end else m_err = 1'b1;
    hold(1, 0, 10);
    hold(1, 1, 10);
    hold(0, 1, 10);
    hold(0, 0, 10);
  endtask
  task automatic exit_seq();
    if (m_count > 0) begin
      m_count--;
      sb.push_back('{1'b0, m_count, 1'b0, m_count == 0});
    end else m_err = 1'b1;
    hold(0, 1, 10);
    hold(1, 1, 10);
    hold(1, 0, 10);
    hold(0, 0, 10);
  endtask
  task automatic do_clear();
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    m_count = 0;
    m_err = 1'b0;
  endtask
  task automatic check_state(input string nm);
    @(negedge clk);
    chk({nm, "_count"}, 32'(bus.count), 32'(m_count));
    chk({nm, "_full"}, 32'(bus.full), 32'(m_count == CAP));
    chk({nm, "_empty"}, 32'(bus.empty), 32'(m_count == 0));
    chk({nm, "_err"}, 32'(bus.err), 32'(m_err));
    chk({nm, "_pending"}, 32'(sb.size()), 32'd0);
  endtask
  initial begin
    logic seen;
    bus.a = 1'b0;
    bus.b = 1'b0;
    bus.clear = 1'b0;
    repeat (3) @(posedge clk);
    check_state("reset");
    chk("reset_entry_pulse", 32'(bus.entry_pulse), 32'd0);
    chk("reset_exit_pulse", 32'(bus.exit_pulse), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    hold(0, 0, 3);
    entry();
    check_state("first_entry");
    do_clear();
    check_state("clear1");
    for (int i = 0; i < 6; i++) begin
      entry();
      check_state($sformatf("fill%0d", i));
    end
    do_clear();
    check_state("clear_full");
    exit_seq();
    check_state("exit_at_empty");
    do_clear();
    hold(1, 0, 10);
    hold(0, 0, 10);
    check_state("abort_entry");
    hold(1, 0, 10);
    hold(1, 1, 10);
    hold(1, 0, 10);
    hold(0, 0, 10);
    check_state("backed_out");
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.a = (i % 3) != 2;
      @(posedge clk);
      #1;
      seen |= dut.r_deb[0];
    end
    hold(0, 0, 10);
    chk("glitch_debounced_a", 32'(seen), 32'd0);
    check_state("glitch");
    for (int i = 0; i < 3; i++) entry();
    check_state("count3");
    exit_seq();
    entry();
    check_state("exit_then_entry");
    hold(1, 0, 10);
    hold(1, 1, 10);
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset_count", 32'(bus.count), 32'd0);
    chk("async_reset_empty", 32'(bus.empty), 32'd1);
    m_count = 0;
    m_err = 1'b0;
    bus.a = 1'b0;
    bus.b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    hold(0, 0, 10);
    check_state("after_reset");
    entry();
    check_state("entry_after_reset");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
